// File: rtl/spike_event_fifo_if.sv
// spike_event_fifo_if: valid/ready event port carrying {timestamp, state} words.
//   ev_valid : head entry is valid (driven by the FIFO)
//   ev_ready : consumer accepts the head this cycle
//   ev_data  : head event, {timestamp[TS_W-1:0], state[7:0]}
// Modports: master = event producer (FIFO), slave = event consumer.
interface spike_event_fifo_if #(
  parameter int unsigned TS_W = 8
);
  localparam int unsigned DATA_W = TS_W + 8;

  logic              ev_valid;
  logic              ev_ready;
  logic [DATA_W-1:0] ev_data;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: timestamps every spiking cycle of the LIF neuron, buffers
// {ts, state} events in a DEPTH-entry FIFO and drains them on a valid/ready port.
// The neuron cannot stall, so a full FIFO drops the event and sets a sticky flag.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   spike, state : neuron spike flag and membrane state, sampled every edge
//   clear_ovf    : clears the sticky overflow flag (a same-cycle drop wins)
//   ev           : event port (master side), head presented from registers
//   count        : FIFO occupancy 0..DEPTH
//   overflow     : sticky drop flag
//   rate         : spikes in the last ts window
// Optional feature: define SPIKE_EVENT_FIFO_RATE_EN to build the spike-rate
// window counter; otherwise rate is tied to 0.
module spike_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TS_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     spike,
  input  logic [7:0]               state,
  input  logic                     clear_ovf,
  spike_event_fifo_if.master       ev,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               rate
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned DATA_W = TS_W + 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [TS_W-1:0]   ts;

  logic              pop, full, wr_en, drop;
  logic [AW-1:0]     rd_ptr_nxt;
  logic [CW-1:0]     count_nxt;
  logic [DATA_W-1:0] push_word, head_nxt;

  // Push/pop decisions and the next head word, so ev_data/ev_valid stay registered.
  always_comb begin
    push_word  = {ts, state};
    pop        = ev.ev_valid && ev.ev_ready;
    full       = (count == CW'(DEPTH));
    wr_en      = spike && (!full || pop);
    drop       = spike && full && !pop;
    rd_ptr_nxt = rd_ptr + AW'(pop);
    count_nxt  = count;
    if (wr_en && !pop)      count_nxt = count + CW'(1);
    else if (!wr_en && pop) count_nxt = count - CW'(1);
    // The word written this cycle becomes the head when it lands on the next read slot.
    if (count_nxt == '0)                     head_nxt = '0;
    else if (wr_en && wr_ptr == rd_ptr_nxt)  head_nxt = push_word;
    else                                     head_nxt = mem[rd_ptr_nxt];
  end

  // Storage array, no reset needed: the head register gates stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  // Pointers, occupancy, head register, timestamp and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      ev.ev_valid <= 1'b0;
      ev.ev_data  <= '0;
    end else begin
      ts          <= ts + TS_W'(1);
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      ev.ev_valid <= (count_nxt != '0);
      ev.ev_data  <= head_nxt;
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

`ifdef SPIKE_EVENT_FIFO_RATE_EN
  logic [7:0] acc;
  logic [7:0] acc_inc;
  logic       wrap;

  // Saturating spike count including the current cycle; window closes as ts wraps.
  always_comb begin
    acc_inc = (spike && acc != 8'hFF) ? acc + 8'd1 : acc;
    wrap    = (ts == '1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc  <= '0;
      rate <= '0;
    end else if (wrap) begin
      rate <= acc_inc;
      acc  <= '0;
    end else begin
      acc  <= acc_inc;
    end
  end
`else
  assign rate = '0;
`endif
endmodule

// File: tb/tb_spike_event_fifo.sv
// tb_spike_event_fifo: scoreboard bench for spike_event_fifo. A reference model
// pushes expected {ts, state} words on each sampled spike; the monitor compares
// the DUT head/occupancy/flags against the model every cycle.
module tb_spike_event_fifo;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TS_W   = 8;
  localparam int unsigned DATA_W = TS_W + 8;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset_n;
  logic          spike;
  logic [7:0]    state;
  logic          clear_ovf;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    rate;

  spike_event_fifo_if #(.TS_W(TS_W)) ev_if ();

  spike_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spike     (spike),
    .state     (state),
    .clear_ovf (clear_ovf),
    .ev        (ev_if.master),
    .count     (count),
    .overflow  (overflow),
    .rate      (rate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model, advanced on each rising edge from the inputs driven before it.
  logic [DATA_W-1:0] exp_q[$];
  logic [TS_W-1:0]   ts_m;
  logic              ovf_m;
  logic [7:0]        acc_m, rate_m;
  bit                sb_on = 1'b0;
  int                n_pops = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      ts_m   = '0;
      ovf_m  = 1'b0;
      acc_m  = '0;
      rate_m = '0;
    end else begin
      if (exp_q.size() != 0 && ev_if.ev_ready) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (clear_ovf) ovf_m = 1'b0;
      if (spike) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({ts_m, state});
        else                      ovf_m = 1'b1;
      end
`ifdef SPIKE_EVENT_FIFO_RATE_EN
      if (ts_m == {TS_W{1'b1}}) begin
        rate_m = (spike && acc_m != 8'hFF) ? acc_m + 8'd1 : acc_m;
        acc_m  = '0;
      end else if (spike && acc_m != 8'hFF) begin
        acc_m  = acc_m + 8'd1;
      end
`endif
      ts_m = ts_m + TS_W'(1);
    end
  end

  // Monitor: compare DUT outputs against the scoreboard head away from the edge.
  always @(negedge clk) begin
    if (sb_on) begin
      check("count",    32'(count),           32'(exp_q.size()));
      check("ev_valid", 32'(ev_if.ev_valid),  32'(exp_q.size() != 0));
      check("ev_data",  32'(ev_if.ev_data),   (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      check("overflow", 32'(overflow),        32'(ovf_m));
      check("rate",     32'(rate),            32'(rate_m));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto_ts(input logic [TS_W-1:0] target);
    int guard = 0;
    while (ts_m != target && guard < 600) begin
      step();
      guard++;
    end
    check("goto_ts", 32'(ts_m), 32'(target));
  endtask

  logic [TS_W-1:0]   burst_ts;
  logic [DATA_W-1:0] stall_data;

  initial begin
    reset_n        = 1'b0;
    spike          = 1'b0;
    state          = 8'h00;
    clear_ovf      = 1'b0;
    ev_if.ev_ready = 1'b0;
    step(2);
    sb_on = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_data",  32'(ev_if.ev_data), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_rate",  32'(rate), 32'd0);

    // Single spike at ts=5 with immediate drain.
    reset_n = 1'b1;
    ev_if.ev_ready = 1'b1;
    step(5);
    spike = 1'b1; state = 8'h3C;
    step();
    spike = 1'b0;
    check("single_valid", 32'(ev_if.ev_valid), 32'd1);
    check("single_data",  32'(ev_if.ev_data), 32'h053C);
    step();
    check("single_drain", 32'(count), 32'd0);

    // Three-cycle spike at ts 10..12 with the consumer stalled.
    ev_if.ev_ready = 1'b0;
    goto_ts(TS_W'(10));
    for (int i = 1; i <= 3; i++) begin
      spike = 1'b1; state = 8'(8'h11 * i);
      step();
    end
    spike = 1'b0;
    check("burst_count", 32'(count), 32'd3);
    check("burst_head",  32'(ev_if.ev_data), 32'h0A11);
    stall_data = ev_if.ev_data;
    step(2);
    check("stall_stable", 32'(ev_if.ev_data), 32'(stall_data));
    ev_if.ev_ready = 1'b1;
    step();
    check("burst_second", 32'(ev_if.ev_data), 32'h0B22);
    step(3);

    // Ten spikes into a stalled 8-entry FIFO: two drops, sticky overflow.
    ev_if.ev_ready = 1'b0;
    burst_ts = ts_m;
    for (int i = 0; i < 10; i++) begin
      spike = 1'b1; state = 8'(8'hA0 + i);
      step();
    end
    spike = 1'b0;
    check("ovf_count", 32'(count), 32'(DEPTH));
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_head",  32'(ev_if.ev_data), 32'({burst_ts, 8'hA0}));
    spike = 1'b1; clear_ovf = 1'b1; state = 8'hEE;
    step();
    spike = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    step();
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Push and pop together while full: nothing dropped, tail receives the word.
    spike = 1'b1; state = 8'h77; ev_if.ev_ready = 1'b1;
    step();
    spike = 1'b0; ev_if.ev_ready = 1'b0;
    check("full_pp_count", 32'(count), 32'(DEPTH));
    check("full_pp_ovf",   32'(overflow), 32'd0);
    ev_if.ev_ready = 1'b1;
    step(DEPTH + 2);

    // Reset with entries queued discards them; timestamp restarts at 0.
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spike = 1'b1; state = 8'(8'h40 + i);
      step();
    end
    reset_n = 1'b0; spike = 1'b1;
    step();
    reset_n = 1'b1;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("mrst_ovf",   32'(overflow), 32'd0);
    state = 8'h5A;
    step();
    spike = 1'b0;
    check("mrst_ts0", 32'(ev_if.ev_data), 32'h005A);
    ev_if.ev_ready = 1'b1;
    step(2);

    // Rate window: one fully spiking window, then 17 spikes in the next.
    goto_ts('0);
    spike = 1'b1;
    for (int i = 0; i < 256 + 17; i++) begin
      state = 8'(i);
      step();
    end
    spike = 1'b0;
`ifdef SPIKE_EVENT_FIFO_RATE_EN
    check("rate_sat", 32'(rate), 32'd255);
`else
    check("rate_off", 32'(rate), 32'd0);
`endif
    goto_ts('0);
`ifdef SPIKE_EVENT_FIFO_RATE_EN
    check("rate_17", 32'(rate), 32'd17);
`else
    check("rate_off2", 32'(rate), 32'd0);
`endif
    step(2);
    check("pops_seen", 32'(n_pops > 0), 32'd1);

    sb_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
